// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding and default widths for the paired FIFO reader.
package fifo_rd_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF = 8;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;
endpackage

// File: rtl/pair_out_reg.sv
// pair_out_reg: registered operand pair with valid/last; holds under backpressure
// when FIFO_RD_BACKPRESSURE_EN is defined.
module pair_out_reg
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  last_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  ready,
    output logic                  valid,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic                  slot_free,
    output logic                  xfer
);
    logic hold;
`ifdef FIFO_RD_BACKPRESSURE_EN
    assign hold      = valid && !ready;
    assign slot_free = !valid || ready;
    assign xfer      = valid && ready;
`else
    logic unused_ready;
    assign unused_ready = ready;
    assign hold      = 1'b0;
    assign slot_free = 1'b1;
    assign xfer      = valid;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            last  <= 1'b0;
            a     <= '0;
            b     <= '0;
        end else begin
            valid <= load || hold;
            if (load) begin
                a    <= a_in;
                b    <= b_in;
                last <= last_in;
            end
        end
    end
endmodule

// File: rtl/fifo_pair_reader.sv
// fifo_pair_reader: drains len entries from FIFO A and B in lockstep into a valid/last stream.
// Optional output backpressure via FIFO_RD_BACKPRESSURE_EN.
module fifo_pair_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int LEN_WIDTH  = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  a_empty,
    input  logic                  b_empty,
    output logic                  a_rden,
    output logic                  b_rden,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic                  out_last,
    input  logic                  out_ready
);
    rd_state_t state, state_next;
    logic [LEN_WIDTH-1:0] remaining;
    logic rd, slot_free, xfer, is_last;
    assign is_last = remaining == LEN_WIDTH'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= (state == IDLE && start) ? len : rd ? remaining - LEN_WIDTH'(1) : remaining;
            done      <= (state == IDLE && start && len == '0) || (state == DRAIN && xfer && out_last);
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (start && len != '0) ? READ : IDLE;
            READ:    state_next = (rd && is_last) ? DRAIN : READ;
            DRAIN:   state_next = (xfer && out_last) ? IDLE : DRAIN;
            default: state_next = IDLE;
        endcase
    end
    always_comb begin
        busy = state != IDLE;
        rd   = state == READ && !a_empty && !b_empty && slot_free && remaining != '0;
    end
    assign a_rden = rd;
    assign b_rden = rd;
    pair_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rd),
        .last_in  (is_last),
        .a_in     (a_data),
        .b_in     (b_data),
        .ready    (out_ready),
        .valid    (out_valid),
        .last     (out_last),
        .a        (out_a),
        .b        (out_b),
        .slot_free(slot_free),
        .xfer     (xfer)
    );
endmodule

// File: doc/fifo_pair_reader.md
# fifo_pair_reader

Read-side sequencer for the MAC datapath's paired operand FIFOs. On a start command it drains exactly `len` entries from FIFO A and FIFO B in lockstep, issuing `rden` to both only when both are non-empty. It registers each operand pair and presents it to the MAC stage as a valid stream with a last marker, then signals completion. It drives the FIFO read port directly: `rden` is asserted in a cycle, and that FIFO's `o_data` is valid combinationally in the same cycle.

## Interface
- DATA_WIDTH, 8, operand width; must match the FIFOs' data width.
- LEN_WIDTH, 8, width of the transfer length and of the internal remaining counter.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle command; sampled only in IDLE.
- len  in  LEN_WIDTH  number of pairs to transfer; sampled together with start.
- busy  out  1  high in READ and DRAIN.
- done  out  1  one-cycle completion pulse.
- a_empty, b_empty  in  1 each  empty flags from FIFO A and FIFO B.
- a_rden, b_rden  out  1 each  read enables; always equal to each other.
- a_data, b_data  in  DATA_WIDTH each  FIFO outputs; valid only in a cycle where rden is high.
- out_valid  out  1  the pair on out_a/out_b is valid.
- out_a, out_b  out  DATA_WIDTH each  registered operand pair.
- out_last  out  1  marks the final pair of the transfer; qualified by out_valid.
- out_ready  in  1  downstream accept; used only with the macro defined.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE:
  - start with len≠0 loads `remaining=len` and moves to READ.
  - start with len==0 pulses done on the next cycle and stays in IDLE.
- Read condition: `rd = (state==READ) && !a_empty && !b_empty && slot_free`; a_rden = b_rden = rd. The FIFOs are never read while empty, and one FIFO is never read alone.
- On rd:
  - out_a/out_b capture a_data/b_data.
  - out_valid is set.
  - out_last is set to `(remaining==1)`.
  - remaining is decremented.
  - When remaining goes 1→0, the state moves to DRAIN.
- DRAIN: once the last pair is transferred, done pulses for one cycle and the state moves to IDLE.
- start is ignored while busy. len is not re-sampled until the block is back in IDLE.
- remaining never underflows; rd is impossible once remaining==0.
- Reset mid-transfer:
  - All state is cleared immediately and rd drops to 0.
  - Unread FIFO entries stay in the FIFOs.
  - No done is issued.
- Reset values: busy=0, done=0, a_rden=b_rden=0, out_valid=0, out_a=out_b=0, out_last=0, state=IDLE, remaining=0.

## Timing
- rd in cycle N gives out_valid and data in cycle N+1.
- Peak throughput is 1 pair/cycle.
- Transfer definition:
  - With the macro: a cycle with out_valid && out_ready.
  - Without the macro: every cycle with out_valid high.
- done is asserted the cycle after the transfer of the out_last pair.
- Best case for len=L: start at cycle 0, first rd at cycle 1, last pair valid at L+1, done at L+2.
- If either FIFO is empty, rd stalls; the stall adds cycles but never drops or duplicates an entry.
- busy rises the cycle after start and falls in the same cycle that done is asserted.

## Configuration
- FIFO_RD_BACKPRESSURE_EN defined:
  - `slot_free = !out_valid || out_ready`.
  - The output register holds its data while out_valid && !out_ready.
  - rd depends combinationally on out_ready.
- Undefined:
  - slot_free=1 and out_ready is ignored.
  - out_valid is a one-cycle pulse per pair.
  - out_valid clears on any cycle without rd.

## Structure
- Package `fifo_rd_pkg`:
  - `rd_state_t` enum (IDLE, READ, DRAIN).
  - Default DATA_WIDTH and LEN_WIDTH constants.
- Sub-module `pair_out_reg`: the output register with valid/last and optional hold under backpressure. It is instantiated once. The FSM and counter stay in the top module.

## Test plan
- FIFOs preloaded A={1,2,3}, B={4,5,6}, out_ready=1, start with len=3 → pairs (1,4),(2,5),(3,6) on consecutive cycles; out_last only on (3,6); done 1 cycle later; FIFOs empty.
- len=4, A holds 4 entries, B holds 2; B refilled 5 cycles later → rd stays low while b_empty; no one-sided read; all 4 pairs in order; done after the 4th.
- Macro defined, len=3, out_ready low for 3 cycles on the 2nd pair → out_a/out_b held stable; no rd during the stall; no loss or duplication.
- start with len=0 → done exactly 1 cycle later; busy never high; rden never asserted.
- rst_n asserted mid-transfer (len=5, after 2 pairs) → outputs at reset values immediately; no done; next start with len=3 reads the next 3 entries.
- start pulsed while busy → ignored; remaining unaffected; only one done.
